// File: rtl/flappy_pkg.sv
// Shared game-state encoding and elaboration helpers for the flappy control
// blocks. The score and motion blocks decode state_t directly.
package flappy_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    // Larger of two integers, used to size counters shared by two limits.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector: registers the previous level of d and produces a
// combinational one-cycle strobe when d goes from 0 to 1.
module rise_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // History register holding last cycle's level of d.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/collision_handler.sv
// Integrates per-pixel collision over each frame, qualifies a frame-level hit
// and runs the game state machine that gates motion, scrolling and scoring.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | waiting for the player's first flap
//  S_PLAY  | game running, collisions integrated per frame
//  S_DYING | fall animation, DEATH_FRAMES frames, flap ignored
//  S_OVER  | game over screen, flap ignored for HOLDOFF frames
module collision_handler
    import flappy_pkg::*;
#(
    parameter int HIT_THRESH   = 4,
    parameter int DEATH_FRAMES = 60,
    parameter int HOLDOFF      = 30,
    parameter int CNT_W        = 12
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       collision,
    input  logic       flap,
    output logic [1:0] state,
    output logic       play_en,
    output logic       freeze,
    output logic       game_over,
    output logic       hit_pulse,
    output logic       score_clear
);

    localparam int FRM_MAX = max_int(DEATH_FRAMES, HOLDOFF);
    localparam int FRM_W   = $clog2(FRM_MAX + 1);

    localparam logic [CNT_W-1:0] HIT_TH     = CNT_W'(HIT_THRESH);
    localparam logic [FRM_W-1:0] DEATH_LAST = FRM_W'(DEATH_FRAMES - 1);
    localparam logic [FRM_W-1:0] HOLD_CNT   = FRM_W'(HOLDOFF);
    localparam logic [FRM_W-1:0] FRM_LIM    = FRM_W'(FRM_MAX);

    if (HIT_THRESH < 1 || HIT_THRESH >= (1 << CNT_W)) begin : g_bad_hit_thresh
        $error("collision_handler: HIT_THRESH must be in [1, 2**CNT_W)");
    end
    if (DEATH_FRAMES < 1 || HOLDOFF < 1) begin : g_bad_frames
        $error("collision_handler: DEATH_FRAMES and HOLDOFF must be >= 1");
    end

    logic             frame_tick;
    logic             flap_rise;
    logic             frame_hit;
    logic [CNT_W-1:0] hit_cnt;
    logic [FRM_W-1:0] frm_cnt;
    state_t           state_q;
    state_t           state_nxt;
    logic             play_en_nxt;
    logic             freeze_nxt;
    logic             game_over_nxt;
    logic             hit_pulse_nxt;
    logic             score_clear_nxt;

    rise_edge u_frame_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (frame_clk),
        .rise  (frame_tick)
    );

    rise_edge u_flap_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (flap),
        .rise  (flap_rise)
    );

    // Hit decision looks at the count accumulated before the tick cycle; the
    // tick cycle's own collision belongs to the new frame.
    assign frame_hit = (hit_cnt >= HIT_TH);

    // Per-frame collision pixel counter, saturating; only live while staying in PLAY.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit_cnt <= '0;
        end else if (state_q != S_PLAY || state_nxt != S_PLAY) begin
            hit_cnt <= '0;
        end else if (frame_tick) begin
            hit_cnt <= collision ? CNT_W'(1) : '0;
        end else if (collision && hit_cnt != '1) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

    // Frame counter: restarts on every state change, counts ticks in DYING/OVER.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frm_cnt <= '0;
        end else if (state_nxt != state_q) begin
            frm_cnt <= '0;
        end else if (frame_tick && (state_q == S_DYING || state_q == S_OVER)
                     && frm_cnt != FRM_LIM) begin
            frm_cnt <= frm_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; a hit on a frame boundary outranks everything in PLAY.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (flap_rise) state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (frame_tick && frame_hit) state_nxt = S_DYING;
            end
            S_DYING: begin
                if (frame_tick && frm_cnt == DEATH_LAST) state_nxt = S_OVER;
            end
            S_OVER: begin
                // >= keeps the exit open if the shared counter runs past HOLDOFF.
                if (flap_rise && frm_cnt >= HOLD_CNT) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: level outputs from the current state, pulses from transitions.
    always_comb begin
        play_en_nxt     = (state_q == S_PLAY);
        freeze_nxt      = (state_q == S_DYING) || (state_q == S_OVER);
        game_over_nxt   = (state_q == S_OVER);
        hit_pulse_nxt   = (state_q == S_PLAY) && (state_nxt == S_DYING);
        score_clear_nxt = (state_q == S_OVER) && (state_nxt == S_IDLE);
    end

    // Output registers; all outputs clear immediately on reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            play_en     <= 1'b0;
            freeze      <= 1'b0;
            game_over   <= 1'b0;
            hit_pulse   <= 1'b0;
            score_clear <= 1'b0;
        end else begin
            play_en     <= play_en_nxt;
            freeze      <= freeze_nxt;
            game_over   <= game_over_nxt;
            hit_pulse   <= hit_pulse_nxt;
            score_clear <= score_clear_nxt;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_collision_handler.sv
// Directed bench for collision_handler: a vector table covers reset, game
// start and the hit threshold; hand-written sequences cover the dying and
// game-over frame counts, counter saturation and asynchronous reset.
module tb_collision_handler;
    import flappy_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       collision;
    logic       flap;
    logic [1:0] state;
    logic       play_en;
    logic       freeze;
    logic       game_over;
    logic       hit_pulse;
    logic       score_clear;

    int n_checks = 0;
    int n_fail   = 0;

    collision_handler #(
        .HIT_THRESH   (4),
        .DEATH_FRAMES (60),
        .HOLDOFF      (30),
        .CNT_W        (12)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .collision   (collision),
        .flap        (flap),
        .state       (state),
        .play_en     (play_en),
        .freeze      (freeze),
        .game_over   (game_over),
        .hit_pulse   (hit_pulse),
        .score_clear (score_clear)
    );

    // 50 MHz
    always #10 Clk = ~Clk;

    typedef struct {
        logic       flap;
        logic       fclk;
        logic       col;
        logic [1:0] st;
        logic       pe;
        logic       fz;
        logic       go;
        logic       hp;
        logic       sc;
    } vec_t;

    vec_t vecs[13];

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] st, input logic pe,
                            input logic fz, input logic go, input logic hp, input logic sc);
        chk({tag, " state"},       32'(state),       32'(st));
        chk({tag, " play_en"},     32'(play_en),     32'(pe));
        chk({tag, " freeze"},      32'(freeze),      32'(fz));
        chk({tag, " game_over"},   32'(game_over),   32'(go));
        chk({tag, " hit_pulse"},   32'(hit_pulse),   32'(hp));
        chk({tag, " score_clear"}, 32'(score_clear), 32'(sc));
    endtask

    task automatic pulse_frame();
        frame_clk = 1'b1;
        cyc();
        frame_clk = 1'b0;
        cyc();
    endtask

    initial begin
        //              flap fclk col  state  pe fz go hp sc
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        Reset     = 1'b1;
        frame_clk = 1'b0;
        collision = 1'b0;
        flap      = 1'b0;
        cyc();
        chk_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        Reset = 1'b0;

        // Start, 3-pixel frame (no hit), 4-pixel frame (hit).
        for (int i = 0; i < 13; i++) begin
            flap      = vecs[i].flap;
            frame_clk = vecs[i].fclk;
            collision = vecs[i].col;
            cyc();
            chk_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].pe, vecs[i].fz,
                     vecs[i].go, vecs[i].hp, vecs[i].sc);
        end

        // DYING: 59 frames with flap toggling stay in DYING, 60th enters OVER.
        for (int i = 1; i < 60; i++) begin
            flap = (i % 2 == 1);
            pulse_frame();
            chk($sformatf("dying frame %0d state", i), 32'(state), 32'(2));
        end
        flap      = 1'b0;
        frame_clk = 1'b1;
        cyc();
        chk("dying->over state", 32'(state), 32'(3));
        chk("dying->over game_over lag", 32'(game_over), 32'(0));
        frame_clk = 1'b0;
        cyc();
        chk_outs("over entry", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // OVER: flap edge at frame 10 ignored.
        for (int i = 0; i < 10; i++) pulse_frame();
        flap = 1'b1;
        cyc();
        chk("over flap@10 state", 32'(state), 32'(3));
        flap = 1'b0;
        cyc();
        for (int i = 0; i < 19; i++) pulse_frame();
        // Edge at frame 29 ignored, then held high across frame 30.
        flap = 1'b1;
        cyc();
        chk("over flap@29 state", 32'(state), 32'(3));
        pulse_frame();
        repeat (3) cyc();
        chk("over held flap state", 32'(state), 32'(3));
        chk("over held flap score_clear", 32'(score_clear), 32'(0));
        flap = 1'b0;
        cyc();
        chk("over flap low state", 32'(state), 32'(3));
        flap = 1'b1;
        cyc();
        chk("over->idle state", 32'(state), 32'(0));
        chk("over->idle score_clear", 32'(score_clear), 32'(1));
        chk("over->idle game_over lag", 32'(game_over), 32'(1));
        cyc();
        chk_outs("idle after over", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation: 4099 collision cycles would wrap to 3 (< thresh) without it.
        flap = 1'b0;
        cyc();
        flap = 1'b1;
        cyc();
        chk("sat start state", 32'(state), 32'(1));
        flap      = 1'b0;
        collision = 1'b1;
        repeat (4099) cyc();
        chk_outs("sat mid-frame", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        collision = 1'b0;
        frame_clk = 1'b1;
        cyc();
        chk("sat tick state", 32'(state), 32'(2));
        chk("sat tick hit_pulse", 32'(hit_pulse), 32'(1));
        frame_clk = 1'b0;
        cyc();
        chk_outs("sat after tick", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in DYING mid-frame.
        repeat (3) pulse_frame();
        chk("pre-reset freeze", 32'(freeze), 32'(1));
        #3;
        Reset = 1'b1;
        #1;
        chk_outs("async reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        Reset = 1'b0;
        repeat (5) cyc();
        chk_outs("post reset idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
